// File: rtl/delay_line.sv
// delay_line: programmable-latency delay line built on a circular buffer.
//
// Each enabled edge writes one sample into the buffer and registers the
// sample that was written cur_delay-1 enabled edges earlier onto the output.
// The output stays at zero until enough samples have arrived since the last
// clear ("primed"). This keeps stale buffer contents hidden. The buffer
// itself is never reset.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (overrides everything else)
//   ce         clock enable; the line advances only when high
//   in_data    sample to delay (WIDTH bits)
//   in_valid   qualifier carried alongside in_data
//   delay_ld   load a clamped delay_in; also clears the line (ignores ce)
//   delay_in   requested delay (DW bits); 0 -> 1, >MAX_DELAY -> MAX_DELAY
//   flush      clear the line without changing the delay (ignores ce)
//   out_data   delayed sample, registered, 0 while not primed
//   out_valid  delayed in_valid, registered, 0 while not primed
//   primed     line holds cur_delay samples taken since the last clear
//   cur_delay  delay currently in force
module delay_line #(
  parameter int WIDTH         = 8,
  parameter int MAX_DELAY     = 16,
  parameter int DEFAULT_DELAY = 1,
  localparam int DW           = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             delay_ld,
  input  logic [DW-1:0]    delay_in,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             primed,
  output logic [DW-1:0]    cur_delay
);

  localparam int PW = $clog2(MAX_DELAY);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DELAY);

  logic [WIDTH:0]   mem_q [MAX_DELAY];

  logic [PW-1:0]    wp_q, wp_d;
  logic [DW-1:0]    fill_q, fill_d;
  logic             primed_q, primed_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [DW-1:0]    cur_delay_q, cur_delay_d;

  logic             clr;
  logic             wr_en;
  logic [DW-1:0]    delay_clamped;
  logic [PW-1:0]    dm1;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH:0]   rd_word;
  logic [DW-1:0]    fill_inc;

  always_comb begin
    clr           = delay_ld | flush;
    wr_en         = 1'b0;
    delay_clamped = delay_in;
    if (delay_in == '0) begin
      delay_clamped = DW'(1);
    end else if (delay_in > MAX_D) begin
      delay_clamped = MAX_D;
    end

    // Slot written cur_delay-1 enabled edges ago; the buffer length is not
    // necessarily a power of two, so wrap explicitly. Any truncation of
    // MAX_DELAY to PW bits is harmless because the true result is < MAX_DELAY.
    dm1 = PW'(cur_delay_q - DW'(1));
    if (wp_q >= dm1) begin
      rd_ptr = wp_q - dm1;
    end else begin
      rd_ptr = wp_q - dm1 + PW'(MAX_DELAY);
    end

    // With a delay of one the slot being read is the one being written now,
    // so take the input directly.
    if (cur_delay_q == DW'(1)) begin
      rd_word = {in_valid, in_data};
    end else begin
      rd_word = mem_q[rd_ptr];
    end

    fill_inc = (fill_q == MAX_D) ? MAX_D : fill_q + DW'(1);

    wp_d        = wp_q;
    fill_d      = fill_q;
    primed_d    = primed_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    cur_delay_d = cur_delay_q;

    if (clr) begin
      fill_d      = '0;
      primed_d    = 1'b0;
      out_data_d  = '0;
      out_valid_d = 1'b0;
      if (delay_ld) begin
        cur_delay_d = delay_clamped;
      end
    end else if (ce) begin
      wr_en       = 1'b1;
      wp_d        = (wp_q == PW'(MAX_DELAY - 1)) ? '0 : wp_q + PW'(1);
      fill_d      = fill_inc;
      primed_d    = (fill_inc >= cur_delay_q);
      out_data_d  = primed_d ? rd_word[WIDTH-1:0] : '0;
      out_valid_d = primed_d & rd_word[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp_q        <= '0;
      fill_q      <= '0;
      primed_q    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cur_delay_q <= DW'(DEFAULT_DELAY);
    end else begin
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      primed_q    <= primed_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      cur_delay_q <= cur_delay_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem_q[wp_q] <= {in_valid, in_data};
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;
  assign cur_delay = cur_delay_q;

endmodule

// File: tb/tb_delay_line.sv
module tb_delay_line;
  localparam int WIDTH = 8;
  localparam int MAXD  = 12;
  localparam int DW    = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ce;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             delay_ld;
  logic [DW-1:0]    delay_in;
  logic             flush;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             primed;
  logic [DW-1:0]    cur_delay;

  int n_chk  = 0;
  int n_pass = 0;

  delay_line #(.WIDTH(WIDTH), .MAX_DELAY(MAXD), .DEFAULT_DELAY(1)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_data(in_data), .in_valid(in_valid),
    .delay_ld(delay_ld), .delay_in(delay_in), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .primed(primed),
    .cur_delay(cur_delay)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input int d, input int v, input int p);
    check({tag, ".data"},   int'(out_data),  d);
    check({tag, ".valid"},  int'(out_valid), v);
    check({tag, ".primed"}, int'(primed),    p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int d);
    delay_ld = 1'b1;
    delay_in = DW'(d);
    tick();
    delay_ld = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ce = 1'b1; in_data = 8'd55; in_valid = 1'b1;
    delay_ld = 1'b1; delay_in = 4'd7; flush = 1'b0;
    tick(); tick();
    chk_out("reset", 0, 0, 0);
    check("reset.cur_delay", int'(cur_delay), 1);
    delay_ld = 1'b0;
    rst_n = 1'b1;

    // D=1: one register stage
    for (int i = 1; i <= 3; i++) begin
      in_data = 8'(i);
      tick();
      chk_out($sformatf("d1.e%0d", i), i, 1, 1);
    end

    // D=5 priming
    load(5);
    check("ld5.cur_delay", int'(cur_delay), 5);
    chk_out("ld5.clear", 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      in_data = 8'(10 + k);
      tick();
      if (k < 4)       chk_out($sformatf("d5.e%0d", k + 1), 0, 0, 0);
      else if (k == 4) chk_out("d5.e5", 10, 1, 1);
      else             chk_out("d5.e6", 11, 1, 1);
    end

    // D=3 with a ce gap
    load(3);
    in_data = 8'd20; tick(); chk_out("d3.e1", 0, 0, 0);
    in_data = 8'd21; tick(); chk_out("d3.e2", 0, 0, 0);
    in_data = 8'd22; tick(); chk_out("d3.e3", 20, 1, 1);
    in_data = 8'd23; tick(); chk_out("d3.e4", 21, 1, 1);
    ce = 1'b0; in_data = 8'd99; in_valid = 1'b0;
    for (int g = 0; g < 3; g++) begin
      tick();
      chk_out($sformatf("d3.gap%0d", g), 21, 1, 1);
    end
    ce = 1'b1; in_valid = 1'b1;
    in_data = 8'd24; tick(); chk_out("d3.r1", 22, 1, 1);
    in_data = 8'd25; tick(); chk_out("d3.r2", 23, 1, 1);
    in_data = 8'd26; tick(); chk_out("d3.r3", 24, 1, 1);

    // clamp boundaries
    load(0);
    check("clamp0.cur_delay", int'(cur_delay), 1);
    load(MAXD + 3);
    check("clampmax.cur_delay", int'(cur_delay), MAXD);
    for (int k = 0; k < MAXD; k++) begin
      in_data = 8'(40 + k);
      tick();
      if (k == MAXD - 2) chk_out("d12.e11", 0, 0, 0);
      if (k == MAXD - 1) chk_out("d12.e12", 40, 1, 1);
    end
    in_data = 8'd60; tick(); chk_out("d12.e13", 41, 1, 1);

    // flush alone keeps delay, delay_ld+flush with ce low behaves as delay_ld
    flush = 1'b1; tick(); flush = 1'b0;
    chk_out("flush", 0, 0, 0);
    check("flush.cur_delay", int'(cur_delay), MAXD);
    ce = 1'b0; flush = 1'b1; load(4); flush = 1'b0; ce = 1'b1;
    check("ldfl.cur_delay", int'(cur_delay), 4);
    chk_out("ldfl.clear", 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(70 + k);
      tick();
      if (k == 2) check("d4.e3.primed", int'(primed), 0);
    end
    chk_out("d4.e4", 70, 1, 1);

    // reset mid-stream overrides ce/delay_ld/flush
    rst_n = 1'b0; delay_ld = 1'b1; delay_in = 4'd7; flush = 1'b1;
    tick();
    rst_n = 1'b1; delay_ld = 1'b0; flush = 1'b0;
    chk_out("midrst", 0, 0, 0);
    check("midrst.cur_delay", int'(cur_delay), 1);
    in_data = 8'd77; tick(); chk_out("midrst.e1", 77, 1, 1);

    // in_valid pattern with D=2
    load(2);
    in_data = 8'd50; in_valid = 1'b1; tick(); chk_out("v.e1", 0, 0, 0);
    in_data = 8'd51; in_valid = 1'b0; tick(); chk_out("v.e2", 50, 1, 1);
    in_data = 8'd52; in_valid = 1'b1; tick(); chk_out("v.e3", 51, 0, 1);
    in_data = 8'd53; in_valid = 1'b1; tick(); chk_out("v.e4", 52, 1, 1);

    // reload with the same delay still clears
    load(2);
    chk_out("same_ld", 0, 0, 0);
    check("same_ld.cur_delay", int'(cur_delay), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data width in bits (>=1).
REQ-002 The module SHALL have parameter MAX_DELAY, default 16, meaning the largest selectable delay in clock-enabled cycles (>=2).
REQ-003 The module SHALL have parameter DEFAULT_DELAY, default 1, meaning the delay after reset (1..MAX_DELAY).
REQ-004 The module SHALL have localparam DW = clog2(MAX_DELAY+1), meaning the delay-field width.
REQ-005 The module SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  rising-edge clock; every register SHALL be clocked by it.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 ce  input  1  clock enable; the line advances only on edges with ce=1.
REQ-009 in_data  input  WIDTH  sample to be delayed.
REQ-010 in_valid  input  1  qualifier carried alongside in_data.
REQ-011 delay_ld  input  1  strobe to load a new delay from delay_in.
REQ-012 delay_in  input  DW  requested delay.
REQ-013 flush  input  1  discards line contents.
REQ-014 out_data  output  WIDTH  delayed sample, registered.
REQ-015 out_valid  output  1  delayed in_valid, gated by primed, registered.
REQ-016 primed  output  1  high once the line holds cur_delay post-load samples.
REQ-017 cur_delay  output  DW  delay currently in force.

Function
REQ-018 With delay D=cur_delay and ce held high, a sample present before edge n SHALL appear on out_data/out_valid after edge n+D-1 (latency D cycles; D=1 means one register stage).
REQ-019 With ce low, the write pointer, fill count, out_data, out_valid and primed SHALL all hold their values, and in_data/in_valid SHALL be ignored.
REQ-020 Latency SHALL count enabled edges only, so a stream with ce gaps emerges in order with no sample lost or duplicated.
REQ-021 Storage SHALL be a circular buffer of MAX_DELAY entries of WIDTH+1 bits with a write pointer wrapping from MAX_DELAY-1 to 0; its contents SHALL NOT be reset.
REQ-022 delay_ld SHALL act on any edge regardless of ce; cur_delay SHALL take the clamped delay_in after that edge.
REQ-023 The clamp SHALL map delay_in=0 to 1, delay_in>MAX_DELAY to MAX_DELAY, and all other values to themselves.
REQ-024 delay_ld or flush (either or both, regardless of ce) SHALL clear the fill count, primed, out_valid and out_data to 0; the sample present on that edge SHALL be discarded.
REQ-025 The fill count SHALL increment on each subsequent enabled edge and saturate at MAX_DELAY.
REQ-026 primed SHALL rise on the enabled edge where fill reaches cur_delay; on that edge out_data SHALL equal the first post-clear sample.
REQ-027 While primed=0, out_data SHALL be 0 and out_valid SHALL be 0, so stale buffer contents are never exposed.
REQ-028 While primed=1, out_valid SHALL equal the delayed in_valid; out_data SHALL pass through unchanged whatever the value of in_valid.
REQ-029 delay_ld and flush on the same edge SHALL behave as delay_ld alone.
REQ-030 A delay_ld whose clamped value equals cur_delay SHALL still clear the line.

Reset
REQ-031 rst_n=0 at an edge SHALL override ce, delay_ld and flush.
REQ-032 After that edge, cur_delay SHALL be DEFAULT_DELAY, and the write pointer, fill count, primed, out_valid and out_data SHALL all be 0.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight samples; after release, priming SHALL restart per REQ-025 and REQ-026.

Verification
REQ-034 Reset, then DEFAULT_DELAY=1, ce=1, in_data=1,2,3, in_valid=1 -> after edges 1,2,3 out_data=1,2,3, out_valid=1, primed=1 from edge 1.
REQ-035 delay_ld with delay_in=5, then in_data=10,11,12,... on consecutive enabled edges -> primed=0 and out_data=0 for post-load edges 1-4; at edge 5 primed=1, out_data=10; at edge 6 out_data=11.
REQ-036 D=3 streaming, ce=0 for 3 cycles mid-stream -> outputs frozen during the gap; afterwards the sequence resumes with no gap or repeat in the data.
REQ-037 delay_in=0 -> cur_delay=1; delay_in=MAX_DELAY+3 (use WIDTH=8, MAX_DELAY=12 so DW=4) -> cur_delay=12, primed after 12 enabled edges.
REQ-038 flush and delay_ld(4) on the same edge -> cur_delay=4 and the line cleared; rst_n=0 mid-stream -> next edge all outputs 0 and cur_delay=DEFAULT_DELAY.
REQ-039 in_valid toggling 1,0,1 with D=2 -> out_valid reproduces 1,0,1 two cycles later, with out_data following unchanged.
